opt_cmd_gen: RTL

Transmitter side of the `opt_t` command stream: generates the per-replica-group optimisation commands (move type, city indices K/L, Metropolis and exchange random words) that the replica nodes consume. It sits between the host-side run control and the node array. For each sweep it emits one command per `base_id`, using a deterministic xorshift32 PRNG. Its output sequence depends only on `seed` and never on backpressure.

---
 rtl/opt_cmd_gen_pkg.sv | 43 ++++
 rtl/opt_cmd_gen_xorshift32.sv | 28 ++
 rtl/opt_cmd_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/opt_cmd_gen_pkg.sv
// rtl/opt_cmd_gen_pkg.sv - shared types and constants for the opt_t command stream
package opt_cmd_gen_pkg;

   localparam int base_num  = 10;
   localparam int base_log  = 4;
   localparam int city_num  = 100;
   localparam int city_log  = 7;
   localparam int siter_log = 10;

   typedef enum logic [1:0] {
      TWO = 2'd0,
      OR0 = 2'd1,
      OR1 = 2'd2,
      THR = 2'd3
   } opt_command_t;

   typedef struct packed {
      logic [base_log-1:0] base_id;
      opt_command_t        com;
      logic [city_log-1:0] K;
      logic [city_log-1:0] L;
      logic [31:0]         r_metropolis;
      logic [31:0]         r_exchange;
   } opt_t;

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      RM,
      RX,
      SEND
   } opt_gen_state_t;

   function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
      logic [31:0] v;
      v = x;
      v = v ^ (v << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

endpackage

// File: rtl/opt_cmd_gen_xorshift32.sv
// rtl/opt_cmd_gen_xorshift32.sv - xorshift32 PRNG; out is the word the next step will store
module xorshift32
   import opt_cmd_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] out
);

   logic [31:0] state;

   // Exposing the stepped value lets the consumer use a fresh word in the same cycle it steps.
   assign out = xorshift32_step(state);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= 32'h1;
      end else if (load) begin
         state <= (seed == 32'h0) ? 32'h1 : seed;
      end else if (step) begin
         state <= out;
      end
   end

endmodule

// File: rtl/opt_cmd_gen.sv
// rtl/opt_cmd_gen.sv - opt_t command generator; OR-opt moves enabled by OPT_OR_EN
module opt_cmd_gen
   import opt_cmd_gen_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        seed,
   input  logic [siter_log:0] siter,
   output logic               opt_valid,
   input  logic               opt_ready,
   output opt_t               opt_data,
   output logic               busy,
   output logic               done
);

   localparam logic [city_log-1:0]  city_max  = city_log'(city_num);
   localparam logic [base_log-1:0]  base_last = base_log'(base_num - 1);
   localparam logic [siter_log:0]   siter_one = (siter_log+1)'(1);

   opt_gen_state_t       state, state_nxt;
   logic [31:0]          word;
   logic                 prng_load, prng_step;
   logic [siter_log:0]   siter_r, sweep_cnt;
   logic                 handshake, last;
   logic                 reject;
   logic [city_log-1:0]  a, b, lo, hi, k_v, l_v;
   opt_command_t         com_dec;

   xorshift32 u_prng (
      .clk   (clk),
      .reset (reset),
      .load  (prng_load),
      .seed  (seed),
      .step  (prng_step),
      .out   (word)
   );

   always_comb begin
      a       = word[8:2];
      b       = word[15:9];
`ifdef OPT_OR_EN
      case (word[1:0])
         2'b10:   com_dec = OR0;
         2'b11:   com_dec = OR1;
         default: com_dec = TWO;
      endcase
`else
      com_dec = TWO;
`endif
      reject  = (a == '0) || (b == '0) || (a >= city_max) || (b >= city_max) || (a == b);
`ifdef OPT_OR_EN
      // An OR1 move needs a gap of at least two cities between its endpoints.
      if (com_dec == OR1 && ((a - b) == city_log'(1) || (b - a) == city_log'(1))) begin
         reject = 1'b1;
      end
`endif
      lo  = (a < b) ? a : b;
      hi  = (a < b) ? b : a;
      k_v = (com_dec == OR1) ? hi : lo;
      l_v = (com_dec == OR1) ? lo : hi;
   end

   assign handshake = opt_valid && opt_ready;
   assign last      = (opt_data.base_id == base_last) && (sweep_cnt == siter_r - siter_one);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      prng_load = 1'b0;
      prng_step = 1'b0;
      opt_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               prng_load = 1'b1;
               if (siter != '0) state_nxt = DRAW;
            end
         end
         DRAW: begin
            prng_step = 1'b1;
            if (!reject) state_nxt = RM;
         end
         RM: begin
            prng_step = 1'b1;
            state_nxt = RX;
         end
         RX: begin
            prng_step = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            opt_valid = 1'b1;
            if (opt_ready) state_nxt = last ? IDLE : DRAW;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opt_data  <= '0;
         siter_r   <= '0;
         sweep_cnt <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  siter_r          <= siter;
                  sweep_cnt        <= '0;
                  opt_data.base_id <= '0;
                  if (siter == '0) done <= 1'b1;
               end
            end
            DRAW: begin
               if (!reject) begin
                  opt_data.com <= com_dec;
                  opt_data.K   <= k_v;
                  opt_data.L   <= l_v;
               end
            end
            RM:   opt_data.r_metropolis <= word;
            RX:   opt_data.r_exchange   <= word;
            SEND: begin
               if (handshake) begin
                  if (opt_data.base_id == base_last) begin
                     opt_data.base_id <= '0;
                     sweep_cnt        <= sweep_cnt + siter_one;
                  end else begin
                     opt_data.base_id <= opt_data.base_id + base_log'(1);
                  end
                  if (last) done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
